// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the run/stop/clear controller of the 4-digit counter.
// Latency: none (declarations only).
// Backpressure: none.
// Contents: ctrl_state_t, NUM_DIGITS, AN_RST anode reset pattern, anode_of() decoder.
package count_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = $clog2(NUM_DIGITS);

  // Digit 0 lit, all others dark (active-low anodes).
  localparam logic [NUM_DIGITS-1:0] AN_RST = 4'b1110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ctrl_state_t;

  // Active-low one-hot anode drive for a digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_of(input logic [SEL_W-1:0] sel);
    return ~(NUM_DIGITS'(1) << sel);
  endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// Bundle of the controller's front-panel, counter and display signals.
// Latency: none (wiring only).
// Backpressure: none; every signal is a plain level or single-cycle pulse.
// Ports: clk_div/btn_run/btn_clr/cnt_max in, cnt_en/cnt_clr/running/scan_sel/an_n out
//        (directions as seen by the controller through the slave modport).
interface count_ctrl_if;
  import count_ctrl_pkg::*;

  logic                  clk_div;
  logic                  btn_run;
  logic                  btn_clr;
  logic                  cnt_max;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  running;
  logic [SEL_W-1:0]      scan_sel;
  logic [NUM_DIGITS-1:0] an_n;

  // Environment side: divider, debouncers, counter datapath, display.
  modport master (
    output clk_div, btn_run, btn_clr, cnt_max,
    input  cnt_en, cnt_clr, running, scan_sel, an_n
  );

  // Controller side.
  modport slave (
    input  clk_div, btn_run, btn_clr, cnt_max,
    output cnt_en, cnt_clr, running, scan_sel, an_n
  );

endinterface

// File: rtl/count_ctrl_edge_det.sv
// Rising-edge detector: rise = d & ~d_q, d_q being d from the previous mclk cycle.
// Latency: combinational from d (one registered stage of history).
// Backpressure: none.
// Ports: mclk, rst (sync, active-high), d (level in), rise (edge out).
module edge_det (
  input  logic mclk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // d_q clears on reset, so a level already high at release yields one edge.
  always_ff @(posedge mclk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/count_ctrl.sv
// Run/stop/clear controller: turns divider ticks and button edges into count pulses, plus display scan.
// Latency: an edge on cycle N shows as cnt_en/cnt_clr/running change on cycle N+1 (all outputs registered).
// Backpressure: none; inputs are sampled every cycle and pulses are never held or queued.
// Ports: mclk, rst (sync, active-high), bus (count_ctrl_if.slave: clk_div, btn_run, btn_clr,
//        cnt_max in; cnt_en, cnt_clr, running, scan_sel, an_n out).
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter bit WRAP     = 1'b1
) (
  input  logic         mclk,
  input  logic         rst,
  count_ctrl_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);

  logic tick;
  logic run_rise;
  logic clr_rise;

  edge_det u_tick (.mclk(mclk), .rst(rst), .d(bus.clk_div), .rise(tick));
  edge_det u_run  (.mclk(mclk), .rst(rst), .d(bus.btn_run), .rise(run_rise));
  edge_det u_clr  (.mclk(mclk), .rst(rst), .d(bus.btn_clr), .rise(clr_rise));

  // ---------------------------------------------------------------- FSM
  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic        en_nxt;
  logic        clr_nxt;
  logic        cnt_en_q;
  logic        cnt_clr_q;
  logic        running_q;

  always_comb begin
    state_nxt = state;
    en_nxt    = 1'b0;
    clr_nxt   = 1'b0;
    if (clr_rise) begin
      // Clear wins over any run edge or tick in the same cycle.
      clr_nxt   = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run_rise) state_nxt = RUN;
        end
        RUN: begin
          if (tick) begin
            // Without wrap, a tick at 9999 parks the counter instead of rolling it.
            if (!WRAP && bus.cnt_max) state_nxt = PAUSE;
            else                      en_nxt    = 1'b1;
          end
          // A tick coinciding with the pause edge is still counted.
          if (run_rise) state_nxt = PAUSE;
        end
        PAUSE: begin
          if (run_rise) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt_en_q  <= en_nxt;
      cnt_clr_q <= clr_nxt;
      running_q <= (state_nxt == RUN);
    end
  end

  // ---------------------------------------------------------------- display scan
  logic [PW-1:0]         presc;
  logic [SEL_W-1:0]      scan_sel_q;
  logic [SEL_W-1:0]      sel_inc;
  logic [NUM_DIGITS-1:0] an_n_q;

  assign sel_inc = scan_sel_q + SEL_W'(1);

  // Free-running regardless of FSM state; anodes are re-decoded with the select so both move together.
  always_ff @(posedge mclk) begin
    if (rst) begin
      presc      <= '0;
      scan_sel_q <= '0;
      an_n_q     <= AN_RST;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc      <= '0;
      scan_sel_q <= sel_inc;
      an_n_q     <= anode_of(sel_inc);
    end else begin
      presc      <= presc + PW'(1);
    end
  end

  assign bus.cnt_en   = cnt_en_q;
  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.running  = running_q;
  assign bus.scan_sel = scan_sel_q;
  assign bus.an_n     = an_n_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: one WRAP=1 and one WRAP=0 instance share the same stimulus.
// Expected outputs are written into a vector table and queued per cycle, then popped after the clock edge.
module tb_count_ctrl;
  import count_ctrl_pkg::*;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic rst;
  logic clk_div, btn_run, btn_clr, cnt_max;

  count_ctrl_if bus_w ();
  count_ctrl_if bus_s ();

  assign bus_w.clk_div = clk_div;
  assign bus_w.btn_run = btn_run;
  assign bus_w.btn_clr = btn_clr;
  assign bus_w.cnt_max = cnt_max;
  assign bus_s.clk_div = clk_div;
  assign bus_s.btn_run = btn_run;
  assign bus_s.btn_clr = btn_clr;
  assign bus_s.cnt_max = cnt_max;

  count_ctrl #(.SCAN_DIV(16), .WRAP(1'b1)) dut_w (.mclk(mclk), .rst(rst), .bus(bus_w.slave));
  count_ctrl #(.SCAN_DIV(16), .WRAP(1'b0)) dut_s (.mclk(mclk), .rst(rst), .bus(bus_s.slave));

  // Inputs for one cycle and the outputs required on the following cycle.
  typedef struct {
    logic div, run, clr, max;
    logic en_w, run_w, en_s, run_s, clr_o;
  } vec_t;

  typedef struct {
    logic       en_w, run_w, en_s, run_s, clr_o;
    logic [1:0] sel;
    logic [3:0] an;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   scan_n = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
  endtask

  task automatic step(input logic r, input logic d, input logic b, input logic c, input logic m,
                      input logic en_w, input logic run_w, input logic en_s, input logic run_s,
                      input logic clr_o);
    exp_t e;
    @(negedge mclk);
    rst = r; clk_div = d; btn_run = b; btn_clr = c; cnt_max = m;
    if (r) scan_n = 0;
    else   scan_n++;
    e.en_w = en_w; e.run_w = run_w; e.en_s = en_s; e.run_s = run_s; e.clr_o = clr_o;
    e.sel  = 2'((scan_n / 16) % 4);
    e.an   = ~(4'b0001 << e.sel);
    sb.push_back(e);
    @(posedge mclk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 4'd1, 4'd0);
    end else begin
      e = sb.pop_front();
      chk("cnt_en_wrap",   {3'b0, bus_w.cnt_en},  {3'b0, e.en_w});
      chk("running_wrap",  {3'b0, bus_w.running}, {3'b0, e.run_w});
      chk("cnt_clr_wrap",  {3'b0, bus_w.cnt_clr}, {3'b0, e.clr_o});
      chk("cnt_en_sat",    {3'b0, bus_s.cnt_en},  {3'b0, e.en_s});
      chk("running_sat",   {3'b0, bus_s.running}, {3'b0, e.run_s});
      chk("cnt_clr_sat",   {3'b0, bus_s.cnt_clr}, {3'b0, e.clr_o});
      chk("scan_sel_wrap", {2'b0, bus_w.scan_sel}, {2'b0, e.sel});
      chk("an_n_wrap",     bus_w.an_n, e.an);
      chk("scan_sel_sat",  {2'b0, bus_s.scan_sel}, {2'b0, e.sel});
      chk("an_n_sat",      bus_s.an_n, e.an);
    end
  endtask

  vec_t tv[38];

  initial begin
    rst = 1'b1; clk_div = 1'b0; btn_run = 1'b0; btn_clr = 1'b0; cnt_max = 1'b0;

    //               div run clr max | en_w run_w en_s run_s clr
    tv[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tv[1]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // tick in IDLE ignored
    tv[2]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tv[3]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tv[4]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tv[5]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0}; // run edge -> RUN
    tv[6]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0}; // tick 1
    tv[7]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0}; // level held: no second pulse
    tv[8]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0};
    tv[9]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0}; // tick 2
    tv[10] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0};
    tv[11] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0}; // tick 3
    tv[12] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // run edge -> PAUSE
    tv[13] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // tick in PAUSE ignored
    tv[14] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tv[15] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // second ignored tick
    tv[16] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tv[17] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0}; // resume
    tv[18] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0};
    tv[19] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0};
    tv[20] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1}; // clr + tick in RUN
    tv[21] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // clr held: single pulse
    tv[22] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0};
    tv[23] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0}; // tick at 9999
    tv[24] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0};
    tv[25] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0}; // tick + run edge
    tv[26] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tv[27] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0};
    tv[28] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0};
    tv[29] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tv[30] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1}; // clr from RUN / PAUSE
    tv[31] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0}; // tick + run in IDLE
    tv[32] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0};
    tv[33] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0}; // first enable on next tick
    tv[34] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1}; // clr overrides run
    tv[35] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tv[36] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1}; // clr + run in IDLE
    tv[37] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};

    // Reset state.
    step(1'b1, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0);
    step(1'b1, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0);

    // Five divider periods with no buttons: anodes walk through all four digits.
    for (int i = 0; i < 80; i++)
      step(1'b0, 1'((i / 8) % 2), 1'b0, 1'b0, 1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0);

    for (int i = 0; i < 38; i++)
      step(1'b0, tv[i].div, tv[i].run, tv[i].clr, tv[i].max,
           tv[i].en_w, tv[i].run_w, tv[i].en_s, tv[i].run_s, tv[i].clr_o);

    // Enter RUN, hold the run button, and idle until the scan reaches digit 2.
    step(1'b0, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0);
    for (int i = 0; i < 64 && (((scan_n + 1) / 16) % 4) != 2; i++)
      step(1'b0, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0);
    step(1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0);
    step(1'b0, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0);

    // One-cycle reset mid-run with a tick present: nothing emitted, scan back to digit 0.
    step(1'b1, 1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0);
    // Levels still high at release give one edge each: run edge -> RUN, tick not honoured from IDLE.
    step(1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0);
    step(1'b0, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0);
    step(1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0);
    step(1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Run/stop/clear controller for the 4-digit counter. Converts the divided-clock level from the frequency divider into single-cycle count enables and sequences the counter through idle, run and pause states from debounced front-panel buttons. Also generates the digit-scan select and anode drive for the multiplexed 4-digit display. Sits between the divider, the button debouncers and the BCD counter datapath, entirely in the `mclk` domain.

## Interface
- `SCAN_DIV`, default 16: number of `mclk` cycles per displayed digit; legal range ≥ 2.
- `WRAP`, default 1: 1 means the counter rolls over at 9999; 0 means the controller stops the counter at 9999.

- `mclk`, input, 1: the single clock. All logic is on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `clk_div`, input, 1: divided-clock level from the divider, registered in the `mclk` domain. It needs no synchronizer.
- `btn_run`, input, 1: debounced run/pause button level.
- `btn_clr`, input, 1: debounced clear button level.
- `cnt_max`, input, 1: high while the counter holds 9999.
- `cnt_en`, output, 1: one-cycle count-enable pulse to the counter.
- `cnt_clr`, output, 1: one-cycle synchronous clear pulse to the counter.
- `running`, output, 1: high while the state is RUN.
- `scan_sel`, output, 2: index of the digit currently displayed.
- `an_n`, output, 4: active-low one-hot anode drive, equal to `~(4'b0001 << scan_sel)`.

## Operation
- Rising-edge detection applies to `clk_div`, `btn_run` and `btn_clr`.
  - Each rising edge is `x & ~x_q`, where `x_q` is the value registered on the previous cycle.
  - `x_q` resets to 0. A level already high when reset releases therefore produces one edge on the first cycle after reset.
- The FSM has three states: IDLE, RUN and PAUSE. The reset state is IDLE.
- IDLE:
  - A `clr` edge pulses `cnt_clr` and the state stays IDLE.
  - A `run` edge moves the state to RUN.
- RUN:
  - A tick (`clk_div` rising edge) pulses `cnt_en`.
  - A `run` edge moves the state to PAUSE.
  - A `clr` edge pulses `cnt_clr` and moves the state to IDLE.
- PAUSE:
  - A `run` edge moves the state to RUN.
  - A `clr` edge pulses `cnt_clr` and moves the state to IDLE.
  - Ticks are ignored.
- Saturation when `WRAP`=0: a tick in RUN with `cnt_max`=1 does not pulse `cnt_en` and moves the state to PAUSE.
- Saturation when `WRAP`=1: `cnt_max` is ignored.
- Simultaneous events:
  - A `clr` edge overrides a `run` edge and a tick in the same cycle. The result is `cnt_clr` only, no `cnt_en`, and the next state is IDLE.
  - A tick and a `run` edge together in RUN: the tick is honoured (`cnt_en` pulses) and the next state is PAUSE.
  - A tick and a `run` edge together in IDLE or PAUSE: the tick is not honoured. The first enable comes on the next tick.
- `cnt_en` and `cnt_clr` are never high in the same cycle.
- The scan logic runs in every state and is independent of the FSM.
  - The prescaler counts 0 to `SCAN_DIV`-1 and then wraps.
  - On wrap, `scan_sel` increments modulo 4.

## Timing
- Reset values:
  - `cnt_en`, `cnt_clr` and `running` are 0.
  - `scan_sel` is 0 and `an_n` is 4'b1110.
  - The prescaler is 0 and the state is IDLE.
  - All edge registers are 0.
- All outputs are registered.
- An edge present on cycle N gives its `cnt_en`/`cnt_clr` pulse and its state change, including `running`, on cycle N+1.
- `cnt_en` and `cnt_clr` are exactly one `mclk` cycle wide per edge, whatever the input level duration.
- `scan_sel` changes every `SCAN_DIV` cycles. The first change is `SCAN_DIV` cycles after reset deasserts.
- `an_n` changes on the same cycle as `scan_sel`.
- A `rst` asserted mid-operation returns every register to its reset value on the next edge. No `cnt_en` or `cnt_clr` is emitted during reset.

## Structure
- Package `count_ctrl_pkg` holds:
  - the state type `ctrl_state_t` {IDLE, RUN, PAUSE};
  - `NUM_DIGITS` = 4;
  - the anode reset constant 4'b1110.
- Sub-module `edge_det` is a rising-edge detector with `mclk`, `rst`, `d` and `rise`. It is instantiated three times.
- The FSM and the scan prescaler sit in `count_ctrl`.

## Test plan
- Reset, then 5 `clk_div` periods with no buttons: `cnt_en` stays 0, `running`=0, and `an_n` cycles 1110→1101→1011→0111→1110 every 16 cycles.
- `btn_run` edge, then 3 `clk_div` rising edges: `running`=1 from the next cycle and exactly 3 single-cycle `cnt_en` pulses, each 1 cycle after its tick.
- In RUN, a `btn_run` edge and then 2 ticks: the state is PAUSE and there is no `cnt_en`. A further `btn_run` edge and then 1 tick give 1 pulse.
- In RUN, `btn_clr` and a tick on the same cycle: `cnt_clr`=1 for one cycle with `cnt_en`=0, then the state is IDLE and `running`=0.
- With `WRAP`=0 and `cnt_max`=1 in RUN, one tick: no `cnt_en` and the state moves to PAUSE. With `WRAP`=1 the same stimulus gives one `cnt_en` pulse and the state stays RUN.
- `rst` asserted for 1 cycle while in RUN with the scan at digit 2: the next cycle shows `running`=0, `scan_sel`=0 and `an_n`=1110.
